// File: rtl/multicycle_control_fsm.sv
// rtl/multicycle_control_fsm.sv - multi-cycle FETCH..WB control sequencer for the alu/datapath muxes.
// Optional mem_ack timeout trap enabled by defining MCFSM_MEM_TIMEOUT_EN.
module multicycle_control_fsm #(
  parameter int MEM_TIMEOUT = 15
) (
  input  logic       clk_i,
  input  logic       reset_i,
  input  logic       instr_valid_i,
  output logic       instr_ready_o,
  input  logic [5:0] op_i,
  input  logic [5:0] func_i,
  input  logic       mem_ack_i,
  output logic       pc_write_o,
  output logic       pc_write_cond_o,
  output logic       pc_src_o,
  output logic       ir_write_o,
  output logic       reg_dst_o,
  output logic       alu_src_a_o,
  output logic [1:0] alu_src_b_o,
  output logic       mem_to_reg_o,
  output logic       reg_write_o,
  output logic       mem_read_o,
  output logic       mem_write_o,
  output logic       binvert_o,
  output logic [1:0] operation_o,
  output logic       illegal_o,
  output logic       mem_timeout_o,
  output logic [3:0] state_o
);

  localparam logic [3:0] S_FETCH     = 4'd0;
  localparam logic [3:0] S_DECODE    = 4'd1;
  localparam logic [3:0] S_MEM_ADDR  = 4'd2;
  localparam logic [3:0] S_MEM_READ  = 4'd3;
  localparam logic [3:0] S_MEM_WB    = 4'd4;
  localparam logic [3:0] S_MEM_WRITE = 4'd5;
  localparam logic [3:0] S_R_EXEC    = 4'd6;
  localparam logic [3:0] S_R_WB      = 4'd7;
  localparam logic [3:0] S_BRANCH    = 4'd8;
  localparam logic [3:0] S_TRAP      = 4'd9;

  localparam logic [5:0] OP_RTYPE = 6'b000000;
  localparam logic [5:0] OP_LW    = 6'b100011;
  localparam logic [5:0] OP_SW    = 6'b101011;
  localparam logic [5:0] OP_BEQ   = 6'b000100;

  logic [3:0] state_q, state_d;
  logic [5:0] op_q, op_d;
  logic [5:0] func_q, func_d;
  logic       r_legal;
  logic [2:0] r_alu;
  logic       waiting;
  logic       timeout_hit;

  assign waiting = (state_q == S_MEM_READ) || (state_q == S_MEM_WRITE);

  // {binvert, operation} for the R-type funct held since FETCH
  always_comb begin
    r_legal = 1'b1;
    r_alu   = 3'b010;
    case (func_q)
      6'b100000: r_alu = 3'b010;
      6'b100010: r_alu = 3'b110;
      6'b100100: r_alu = 3'b000;
      6'b100101: r_alu = 3'b001;
      default:   r_legal = 1'b0;
    endcase
  end

`ifdef MCFSM_MEM_TIMEOUT_EN
  localparam int CW = $clog2(MEM_TIMEOUT + 1);

  logic [CW-1:0] tmo_cnt_q, tmo_cnt_d;
  logic          mem_timeout_q, mem_timeout_d;

  assign timeout_hit = waiting && !mem_ack_i && (tmo_cnt_q == CW'(MEM_TIMEOUT - 1));

  always_comb begin
    tmo_cnt_d     = tmo_cnt_q;
    mem_timeout_d = mem_timeout_q;
    if (state_q == S_MEM_ADDR) begin
      tmo_cnt_d = '0;
    end else if (waiting && !mem_ack_i && !timeout_hit) begin
      tmo_cnt_d = tmo_cnt_q + 1'b1;
    end
    if (timeout_hit) begin
      mem_timeout_d = 1'b1;
    end
  end

  always_ff @(posedge clk_i or posedge reset_i) begin
    if (reset_i) begin
      tmo_cnt_q     <= '0;
      mem_timeout_q <= 1'b0;
    end else begin
      tmo_cnt_q     <= tmo_cnt_d;
      mem_timeout_q <= mem_timeout_d;
    end
  end

  assign mem_timeout_o = mem_timeout_q;
`else
  assign timeout_hit   = 1'b0;
  assign mem_timeout_o = 1'b0;
`endif

  always_comb begin
    state_d = state_q;
    op_d    = op_q;
    func_d  = func_q;
    case (state_q)
      S_FETCH: begin
        if (instr_valid_i) begin
          op_d    = op_i;
          func_d  = func_i;
          state_d = S_DECODE;
        end
      end
      S_DECODE: begin
        if (op_q == OP_LW || op_q == OP_SW)        state_d = S_MEM_ADDR;
        else if (op_q == OP_BEQ)                   state_d = S_BRANCH;
        else if (op_q == OP_RTYPE && r_legal)      state_d = S_R_EXEC;
        else                                       state_d = S_TRAP;
      end
      S_MEM_ADDR:  state_d = (op_q == OP_SW) ? S_MEM_WRITE : S_MEM_READ;
      S_MEM_READ:  if (mem_ack_i) state_d = S_MEM_WB;
      S_MEM_WB:    state_d = S_FETCH;
      S_MEM_WRITE: if (mem_ack_i) state_d = S_FETCH;
      S_R_EXEC:    state_d = S_R_WB;
      S_R_WB:      state_d = S_FETCH;
      S_BRANCH:    state_d = S_FETCH;
      S_TRAP:      state_d = S_TRAP;
      default:     state_d = S_TRAP;
    endcase
    if (timeout_hit) begin
      state_d = S_TRAP;
    end
  end

  always_ff @(posedge clk_i or posedge reset_i) begin
    if (reset_i) begin
      state_q <= S_FETCH;
      op_q    <= '0;
      func_q  <= '0;
    end else begin
      state_q <= state_d;
      op_q    <= op_d;
      func_q  <= func_d;
    end
  end

  // Moore decode; reset forces every output low even though state reads FETCH
  always_comb begin
    instr_ready_o   = 1'b0;
    pc_write_o      = 1'b0;
    pc_write_cond_o = 1'b0;
    pc_src_o        = 1'b0;
    ir_write_o      = 1'b0;
    reg_dst_o       = 1'b0;
    alu_src_a_o     = 1'b0;
    alu_src_b_o     = 2'b00;
    mem_to_reg_o    = 1'b0;
    reg_write_o     = 1'b0;
    mem_read_o      = 1'b0;
    mem_write_o     = 1'b0;
    binvert_o       = 1'b0;
    operation_o     = 2'b00;
    illegal_o       = 1'b0;
    if (!reset_i) begin
      case (state_q)
        S_FETCH: begin
          instr_ready_o = 1'b1;
          alu_src_b_o   = 2'b01;
          operation_o   = 2'b10;
          ir_write_o    = instr_valid_i;
          pc_write_o    = instr_valid_i;
        end
        S_DECODE: begin
          alu_src_b_o = 2'b11;
          operation_o = 2'b10;
        end
        S_MEM_ADDR: begin
          alu_src_a_o = 1'b1;
          alu_src_b_o = 2'b10;
          operation_o = 2'b10;
        end
        S_MEM_READ:  mem_read_o = 1'b1;
        S_MEM_WB: begin
          reg_write_o  = 1'b1;
          mem_to_reg_o = 1'b1;
        end
        S_MEM_WRITE: mem_write_o = 1'b1;
        S_R_EXEC: begin
          alu_src_a_o              = 1'b1;
          {binvert_o, operation_o} = r_alu;
        end
        S_R_WB: begin
          alu_src_a_o              = 1'b1;
          {binvert_o, operation_o} = r_alu;
          reg_write_o              = 1'b1;
          reg_dst_o                = 1'b1;
        end
        S_BRANCH: begin
          alu_src_a_o     = 1'b1;
          binvert_o       = 1'b1;
          operation_o     = 2'b10;
          pc_write_cond_o = 1'b1;
          pc_src_o        = 1'b1;
        end
        S_TRAP:  illegal_o = 1'b1;
        default: illegal_o = 1'b0;
      endcase
    end
  end

  assign state_o = state_q;

endmodule

// File: tb/tb_multicycle_control_fsm.sv
// tb/tb_multicycle_control_fsm.sv - directed and randomized checks of multicycle_control_fsm.
module tb_multicycle_control_fsm;

  logic       clk = 1'b0;
  logic       reset, instr_valid, mem_ack;
  logic [5:0] op, func;
  logic       instr_ready, pc_write, pc_write_cond, pc_src, ir_write, reg_dst, alu_src_a;
  logic [1:0] alu_src_b, operation;
  logic       mem_to_reg, reg_write, mem_read, mem_write, binvert, illegal, mem_timeout;
  logic [3:0] state;

  int checks = 0;
  int errors = 0;

  multicycle_control_fsm #(.MEM_TIMEOUT(4)) dut (
    .clk_i(clk), .reset_i(reset), .instr_valid_i(instr_valid), .instr_ready_o(instr_ready),
    .op_i(op), .func_i(func), .mem_ack_i(mem_ack), .pc_write_o(pc_write),
    .pc_write_cond_o(pc_write_cond), .pc_src_o(pc_src), .ir_write_o(ir_write),
    .reg_dst_o(reg_dst), .alu_src_a_o(alu_src_a), .alu_src_b_o(alu_src_b),
    .mem_to_reg_o(mem_to_reg), .reg_write_o(reg_write), .mem_read_o(mem_read),
    .mem_write_o(mem_write), .binvert_o(binvert), .operation_o(operation),
    .illegal_o(illegal), .mem_timeout_o(mem_timeout), .state_o(state)
  );

  always #5 clk = ~clk;

  localparam logic [16:0] B_PCW  = 17'h10000;
  localparam logic [16:0] B_PCWC = 17'h08000;
  localparam logic [16:0] B_PCS  = 17'h04000;
  localparam logic [16:0] B_IRW  = 17'h02000;
  localparam logic [16:0] B_RDST = 17'h01000;
  localparam logic [16:0] B_SA   = 17'h00800;
  localparam logic [16:0] B_M2R  = 17'h00100;
  localparam logic [16:0] B_RW   = 17'h00080;
  localparam logic [16:0] B_MR   = 17'h00040;
  localparam logic [16:0] B_MW   = 17'h00020;
  localparam logic [16:0] B_ILL  = 17'h00002;
  localparam logic [16:0] B_RDY  = 17'h00001;

  localparam logic [5:0] R_FUNC [4] = '{6'b100000, 6'b100010, 6'b100100, 6'b100101};
  localparam logic [2:0] R_ALU  [4] = '{3'b010, 3'b110, 3'b000, 3'b001};

  typedef struct {
    int          st;
    logic [16:0] v;
    bit          ack;
  } step_t;

  step_t exp_q[$];

  function automatic logic [16:0] sb(input logic [1:0] x);
    return 17'(x) << 9;
  endfunction

  function automatic logic [16:0] alu(input logic [2:0] x);
    return 17'(x) << 2;
  endfunction

  function automatic logic [16:0] outv();
    return {pc_write, pc_write_cond, pc_src, ir_write, reg_dst, alu_src_a, alu_src_b,
            mem_to_reg, reg_write, mem_read, mem_write, binvert, operation, illegal, instr_ready};
  endfunction

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  task automatic check_now(input string tag, input int st, input logic [16:0] v,
                           input logic tmo = 1'b0);
    chk({tag, "_state"}, 32'(state), 32'(st));
    chk({tag, "_outs"}, 32'(outv()), 32'(v));
    chk({tag, "_tmo"}, 32'(mem_timeout), 32'(tmo));
  endtask

  task automatic cyc();
    @(posedge clk);
    #1;
  endtask

  function automatic logic [16:0] fetch_v(input bit xfer);
    return B_RDY | sb(2'b01) | alu(3'b010) | (xfer ? (B_PCW | B_IRW) : 17'h0);
  endfunction

  task automatic transfer(input logic [5:0] o, input logic [5:0] f, input int idle);
    repeat (idle) begin
      instr_valid = 1'b0;
      op          = 6'($urandom);
      func        = 6'($urandom);
      mem_ack     = 1'($urandom);
      #1;
      check_now("idle", 0, fetch_v(1'b0));
      cyc();
    end
    instr_valid = 1'b1;
    op          = o;
    func        = f;
    mem_ack     = 1'b0;
    #1;
    check_now("xfer", 0, fetch_v(1'b1));
    cyc();
    instr_valid = 1'b0;
    op          = 6'($urandom);
    func        = 6'($urandom);
  endtask

  // kind: 0=R-type 1=lw 2=sw 3=beq; w = mem wait cycles before ack
  task automatic run_instr(input int kind, input int fidx, input int w, input int idle);
    logic [5:0] o, f;
    f = 6'($urandom);
    case (kind)
      0:       begin o = 6'b000000; f = R_FUNC[fidx]; end
      1:       o = 6'b100011;
      2:       o = 6'b101011;
      default: o = 6'b000100;
    endcase
    transfer(o, f, idle);
    exp_q.delete();
    exp_q.push_back('{1, sb(2'b11) | alu(3'b010), 1'b0});
    case (kind)
      0: begin
        exp_q.push_back('{6, B_SA | alu(R_ALU[fidx]), 1'b0});
        exp_q.push_back('{7, B_SA | alu(R_ALU[fidx]) | B_RW | B_RDST, 1'b0});
      end
      1, 2: begin
        exp_q.push_back('{2, B_SA | sb(2'b10) | alu(3'b010), 1'b0});
        for (int i = 0; i <= w; i++)
          exp_q.push_back('{(kind == 1) ? 3 : 5, (kind == 1) ? B_MR : B_MW, i == w});
        if (kind == 1) exp_q.push_back('{4, B_RW | B_M2R, 1'b0});
      end
      default: exp_q.push_back('{8, B_SA | alu(3'b110) | B_PCWC | B_PCS, 1'b0});
    endcase
    foreach (exp_q[i]) begin
      if (exp_q[i].st == 3 || exp_q[i].st == 5) mem_ack = exp_q[i].ack;
      else                                      mem_ack = 1'($urandom);
      #1;
      check_now("seq", exp_q[i].st, exp_q[i].v);
      cyc();
    end
    mem_ack = 1'b0;
  endtask

  task automatic trap_then_reset(input logic [5:0] o, input logic [5:0] f);
    transfer(o, f, 0);
    #1;
    check_now("trap_dec", 1, sb(2'b11) | alu(3'b010));
    cyc();
    instr_valid = 1'b1;
    repeat (3) begin
      #1;
      check_now("trap", 9, B_ILL);
      cyc();
    end
    #1;
    reset = 1'b1;
    #1;
    check_now("trap_rst", 0, 17'h0);
    cyc();
    reset       = 1'b0;
    instr_valid = 1'b0;
    #1;
    check_now("trap_rel", 0, fetch_v(1'b0));
    cyc();
  endtask

  initial begin
    reset       = 1'b1;
    instr_valid = 1'b1;
    mem_ack     = 1'b1;
    op          = 6'b000000;
    func        = 6'b100000;
    #1;
    check_now("reset", 0, 17'h0);
    cyc();
    cyc();
    check_now("reset_hold", 0, 17'h0);
    reset       = 1'b0;
    instr_valid = 1'b0;
    mem_ack     = 1'b0;
    #1;
    check_now("post_reset", 0, fetch_v(1'b0));
    cyc();

    for (int k = 0; k < 4; k++) run_instr(0, k, 0, 1);
    run_instr(1, 0, 3, 0);
    run_instr(2, 0, 2, 1);
    run_instr(3, 0, 0, 0);
    run_instr(1, 0, 0, 2);
    run_instr(2, 0, 0, 0);

    trap_then_reset(6'b000010, 6'b100000);
    trap_then_reset(6'b000000, 6'b101010);

    transfer(6'b100011, 6'b000000, 0);
    cyc();
    cyc();
    #1;
    check_now("rd_wait", 3, B_MR);
    reset = 1'b1;
    #1;
    check_now("rd_abort", 0, 17'h0);
    cyc();
    reset = 1'b0;
    #1;
    check_now("rd_rel", 0, fetch_v(1'b0));
    cyc();

`ifdef MCFSM_MEM_TIMEOUT_EN
    transfer(6'b101011, 6'b000000, 0);
    cyc();
    cyc();
    mem_ack = 1'b0;
    for (int i = 0; i < 4; i++) begin
      #1;
      check_now("tmo_wait", 5, B_MW);
      cyc();
    end
    #1;
    check_now("tmo_trap", 9, B_ILL, 1'b1);
    reset = 1'b1;
    #1;
    check_now("tmo_rst", 0, 17'h0);
    cyc();
    reset = 1'b0;
    cyc();
`endif

    for (int n = 0; n < 40; n++)
      run_instr($urandom_range(0, 3), $urandom_range(0, 3), $urandom_range(0, 3),
                $urandom_range(0, 2));
    #1;
    check_now("final", 0, fetch_v(1'b0));

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
